// File: rtl/booth_pkg.sv
// Shared types and widths for the booth multiplier datapath, controller and operand feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

    localparam int BOOTH_WIDTH      = 16;
    localparam int BOOTH_PROD_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_M = 3'd1,
        ST_LOAD_Q = 3'd2,
        ST_BUSY   = 3'd3,
        ST_HOLD   = 3'd4
    } booth_state_e;

    // Counter width able to hold the largest of the three preload values (n-1).
    function automatic int cnt_width(input int m_hold, input int q_hold, input int timeout);
        int mx;
        mx = m_hold;
        if (q_hold > mx) mx = q_hold;
        if (timeout > mx) mx = timeout;
        return (mx <= 1) ? 1 : $clog2(mx);
    endfunction

endpackage

// File: rtl/booth_hold_counter.sv
// Loadable down-counter with zero flag, shared by operand hold and timeout phases.
// Latency: load/decrement visible one cycle later; zero flag is combinational from the count.
// Backpressure: none; load has priority over decrement, count saturates at zero.
module booth_hold_counter #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload wins, otherwise step down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/booth_operand_feeder.sv
// Sequences one operand pair onto the multiplier data_in bus (multiplicand, then multiplier) and returns the product.
// Latency: mul_data/mul_start one cycle after accept; out_valid one cycle after mul_done is sampled in BUSY.
// Backpressure: in_ready only in IDLE; product held with out_valid until out_ready, no overlap of transactions.
module booth_operand_feeder
    import booth_pkg::*;
#(
    parameter int WIDTH   = BOOTH_WIDTH,
    parameter int M_HOLD  = 2,
    parameter int Q_HOLD  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_data,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               timeout_err
);

    localparam int            CW     = cnt_width(M_HOLD, Q_HOLD, TIMEOUT);
    localparam logic [CW-1:0] M_LOAD = CW'(M_HOLD - 1);
    localparam logic [CW-1:0] Q_LOAD = CW'(Q_HOLD - 1);
    localparam logic [CW-1:0] T_LOAD = CW'(TIMEOUT - 1);

    booth_state_e       state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               err_q, err_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]      cnt_load_val;

    logic               accept, done_busy, timeout_hit;

    assign accept      = (state_q == ST_IDLE) && in_valid;
    // A done outside BUSY is a leftover from the previous operation and is ignored.
    assign done_busy   = (state_q == ST_BUSY) && mul_done;
    // Done on the same cycle as the counter expiring takes priority over the timeout.
    assign timeout_hit = (state_q == ST_BUSY) && !mul_done && cnt_zero;

    booth_hold_counter #(
        .CW (CW)
    ) u_hold_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept)                   state_d = ST_LOAD_M;
            ST_LOAD_M: if (cnt_zero)                 state_d = ST_LOAD_Q;
            ST_LOAD_Q: if (cnt_zero)                 state_d = ST_BUSY;
            ST_BUSY:   if (done_busy || timeout_hit) state_d = ST_HOLD;
            ST_HOLD:   if (out_ready)                state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        mul_data  = '0;
        unique case (state_q)
            ST_IDLE:   in_ready = 1'b1;
            ST_LOAD_M: begin mul_start = 1'b1; mul_data = a_q; end
            ST_LOAD_Q: begin mul_start = 1'b1; mul_data = b_q; end
            ST_BUSY:   begin mul_start = 1'b1; mul_data = b_q; end
            ST_HOLD:   out_valid = 1'b1;
            default:   in_ready = 1'b0;
        endcase
    end

    // Hold counter control: preload on entry to each timed phase, count down inside them.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = M_LOAD;
        cnt_dec      = (state_q == ST_LOAD_M) || (state_q == ST_LOAD_Q) || (state_q == ST_BUSY);
        if (accept) begin
            cnt_load     = 1'b1;
            cnt_load_val = M_LOAD;
        end else if ((state_q == ST_LOAD_M) && cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = Q_LOAD;
        end else if ((state_q == ST_LOAD_Q) && cnt_zero) begin
            cnt_load     = 1'b1;
            cnt_load_val = T_LOAD;
        end
    end

    // Operand capture, product capture and sticky timeout flag.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        err_d  = err_q;
        if (accept) begin
            a_d   = in_a;
            b_d   = in_b;
            err_d = 1'b0;
        end
        if (done_busy) begin
            prod_d = mul_product;
        end else if (timeout_hit) begin
            prod_d = '0;
            err_d  = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            err_q  <= err_d;
        end
    end

    assign out_product = prod_q;
    assign timeout_err = err_q;

endmodule
